// File: rtl/trace_pkg.sv
// Shared definitions for the pipeline trace buffer: FSM encoding, entry width and field offsets.
// Entry layout, LSB first: trig flag, stamp, payloads, PCs, channel valids.
package trace_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_POST  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ARMED = ST_ARMED,
      POST  = ST_POST,
      DONE  = ST_DONE
   } trace_state_e;

   localparam int OFF_TRIG  = 0;
   localparam int OFF_STAMP = 1;

   function automatic int entry_w(int num_ch, int pc_w, int data_w, int cnt_w);
      return num_ch * (1 + pc_w + data_w) + cnt_w + 1;
   endfunction

   function automatic int off_data(int cnt_w);
      return OFF_STAMP + cnt_w;
   endfunction

   function automatic int off_pc(int num_ch, int data_w, int cnt_w);
      return off_data(cnt_w) + num_ch * data_w;
   endfunction

   function automatic int off_chv(int num_ch, int pc_w, int data_w, int cnt_w);
      return off_pc(num_ch, data_w, cnt_w) + num_ch * pc_w;
   endfunction

endpackage

// File: rtl/trace_capture_ram.sv
// Trace storage: DEPTH x WIDTH, synchronous write, asynchronous read.
// No backpressure; the write lands at the clock edge, the read follows rd_addr combinationally.
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_dat
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_dat;
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/trace_capture.sv
// Circular pipeline trace buffer with trigger + post window, drained oldest-first over valid/ready;
// entries store at the sampling edge, readout holds while rd_ready is low. TRACE_FILTER_EN: keep only cycles with a ch_valid bit.
module trace_capture
   import trace_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int PC_W      = 12,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4,
   parameter int CNT_W     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*PC_W-1:0]   ch_pc,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic                     arm,
   input  logic                     trig,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [NUM_CH-1:0]        rd_ch_valid,
   output logic [NUM_CH*PC_W-1:0]   rd_pc,
   output logic [NUM_CH*DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]         rd_stamp,
   output logic                     rd_trig,
   output logic [CNT_W-1:0]         cycle_count,
   output logic [1:0]               state,
   output logic                     wrapped
);

   localparam int EW     = entry_w(NUM_CH, PC_W, DATA_W, CNT_W);
   localparam int AW     = $clog2(DEPTH);
   localparam int FW     = AW + 1;
   localparam int O_DATA = off_data(CNT_W);
   localparam int O_PC   = off_pc(NUM_CH, DATA_W, CNT_W);
   localparam int O_CHV  = off_chv(NUM_CH, PC_W, DATA_W, CNT_W);

   logic [1:0]       state_q;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d;
   logic [FW-1:0]    fill_q, remaining_q, post_left_q, fill_d;
   logic             wrapped_q, wrapped_d;
   logic [CNT_W-1:0] cnt_q;
   logic             qual, wr_en, wr_trig, go_done, full;
   logic [EW-1:0]    wr_dat, rd_dat;

`ifdef TRACE_FILTER_EN
   assign qual = |ch_valid;
`else
   assign qual = 1'b1;
`endif

   always_comb begin
      wr_en   = 1'b0;
      wr_trig = 1'b0;
      go_done = 1'b0;
      case (state_q)
         ST_ARMED: begin
            // the trigger cycle is always recorded, qualified or not
            wr_en   = qual | trig;
            wr_trig = trig;
            go_done = trig && (POST_TRIG == 0);
         end
         ST_POST: begin
            wr_en   = qual;
            go_done = qual && (post_left_q == FW'(1));
         end
         default: ;
      endcase
   end

   assign full      = (fill_q == FW'(DEPTH));
   assign wr_ptr_d  = wr_ptr_q + AW'(1);
   assign fill_d    = full ? fill_q : fill_q + FW'(1);
   assign wrapped_d = wrapped_q | full;
   assign wr_dat    = {ch_valid, ch_pc, ch_data, cnt_q, wr_trig};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         remaining_q <= '0;
         post_left_q <= '0;
         wrapped_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
         if (wr_en) begin
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            wrapped_q <= wrapped_d;
         end
         if (go_done) begin
            // once wrapped, the next write slot holds the oldest entry
            state_q     <= ST_DONE;
            rd_ptr_q    <= wrapped_d ? wr_ptr_d : '0;
            remaining_q <= fill_d;
         end
         case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  state_q   <= ST_ARMED;
                  wr_ptr_q  <= '0;
                  fill_q    <= '0;
                  wrapped_q <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (trig && POST_TRIG != 0) begin
                  state_q     <= ST_POST;
                  post_left_q <= FW'(POST_TRIG);
               end
            end
            ST_POST: begin
               if (qual) post_left_q <= post_left_q - FW'(1);
            end
            default: begin
               if (remaining_q == '0) begin
                  state_q <= ST_IDLE;
               end else if (rd_ready) begin
                  rd_ptr_q    <= rd_ptr_q + AW'(1);
                  remaining_q <= remaining_q - FW'(1);
               end
            end
         endcase
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_dat  (wr_dat),
      .rd_addr (rd_ptr_q),
      .rd_dat  (rd_dat)
   );

   // readout fields are forced to zero whenever no entry is presented
   assign rd_valid    = (state_q == ST_DONE) && (remaining_q != '0);
   assign rd_trig     = rd_valid & rd_dat[OFF_TRIG];
   assign rd_stamp    = rd_valid ? rd_dat[OFF_STAMP +: CNT_W] : '0;
   assign rd_data     = rd_valid ? rd_dat[O_DATA +: NUM_CH*DATA_W] : '0;
   assign rd_pc       = rd_valid ? rd_dat[O_PC +: NUM_CH*PC_W] : '0;
   assign rd_ch_valid = rd_valid ? rd_dat[O_CHV +: NUM_CH] : '0;

   assign cycle_count = cnt_q;
   assign state       = state_q;
   assign wrapped     = wrapped_q;

endmodule
